// File: rtl/arm7_alu.sv
// ============================================================================
// Module      : arm7_alu
// Description : ARM7TDMI execute-stage 32-bit ALU (add-with-carry / logic ops,
//               N/Z/C/V flags). Define ALU_OUT_REG_EN to register the outputs.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module arm7_alu (
    input  logic        CLK,
    input  logic        nRESET,
    input  logic [31:0] ADATAIN,
    input  logic [31:0] BDATAIN,
    input  logic        INVA,
    input  logic        INVB,
    input  logic        PASSA,
    input  logic        PASSB,
    input  logic        AND_OP,
    input  logic        ORR_OP,
    input  logic        EOR_OP,
    input  logic        CFLAGIN,
    input  logic        CFLAGUSE,
    output logic [31:0] DATAOUT,
    output logic        CFLAGOUT,
    output logic        VFLAGOUT,
    output logic        NFLAGOUT,
    output logic        ZFLAGOUT
);

    logic [31:0] w_opA;
    logic [31:0] w_opB;
    logic        w_cin;
    logic [32:0] w_sum;
    logic [31:0] w_result;
    logic        w_cFlag;
    logic        w_vFlag;
    logic        w_nFlag;
    logic        w_zFlag;

    assign w_opA = INVA ? ~ADATAIN : ADATAIN;
    assign w_opB = INVB ? ~BDATAIN : BDATAIN;
    // Inversion alone implies a two's-complement subtract, hence the +1.
    assign w_cin = CFLAGUSE ? CFLAGIN : (INVA | INVB);
    assign w_sum = {1'b0, w_opA} + {1'b0, w_opB} + {32'd0, w_cin};

    always_comb begin
        w_result = w_sum[31:0];
        w_cFlag  = w_sum[32];
        w_vFlag  = (w_opA[31] == w_opB[31]) && (w_sum[31] != w_opA[31]);
        if (PASSA) begin
            w_result = w_opA;
            w_cFlag  = CFLAGIN;
            w_vFlag  = 1'b0;
        end else if (PASSB) begin
            w_result = w_opB;
            w_cFlag  = CFLAGIN;
            w_vFlag  = 1'b0;
        end else if (AND_OP) begin
            w_result = w_opA & w_opB;
            w_cFlag  = CFLAGIN;
            w_vFlag  = 1'b0;
        end else if (ORR_OP) begin
            w_result = w_opA | w_opB;
            w_cFlag  = CFLAGIN;
            w_vFlag  = 1'b0;
        end else if (EOR_OP) begin
            w_result = w_opA ^ w_opB;
            w_cFlag  = CFLAGIN;
            w_vFlag  = 1'b0;
        end
    end

    assign w_nFlag = w_result[31];
    assign w_zFlag = (w_result == 32'h0);

`ifdef ALU_OUT_REG_EN
    logic [31:0] r_dataOut;
    logic        r_cFlag;
    logic        r_vFlag;
    logic        r_nFlag;
    logic        r_zFlag;

    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            r_dataOut <= 32'h0;
            r_cFlag   <= 1'b0;
            r_vFlag   <= 1'b0;
            r_nFlag   <= 1'b0;
            r_zFlag   <= 1'b0;
        end else begin
            r_dataOut <= w_result;
            r_cFlag   <= w_cFlag;
            r_vFlag   <= w_vFlag;
            r_nFlag   <= w_nFlag;
            r_zFlag   <= w_zFlag;
        end
    end

    assign DATAOUT  = r_dataOut;
    assign CFLAGOUT = r_cFlag;
    assign VFLAGOUT = r_vFlag;
    assign NFLAGOUT = r_nFlag;
    assign ZFLAGOUT = r_zFlag;
`else
    // Clock and reset are kept as ports for a uniform footprint only.
    wire w_unused = &{1'b0, CLK, nRESET};

    assign DATAOUT  = w_result;
    assign CFLAGOUT = w_cFlag;
    assign VFLAGOUT = w_vFlag;
    assign NFLAGOUT = w_nFlag;
    assign ZFLAGOUT = w_zFlag;
`endif

endmodule

`default_nettype wire

// File: tb/tb_arm7_alu.sv
// ============================================================================
// Module      : tb_arm7_alu
// Description : Self-checking bench for arm7_alu, random stimulus against a
//               behavioural model; follows ALU_OUT_REG_EN like the design.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_arm7_alu;

    logic        CLK = 1'b0;
    logic        nRESET;
    logic [31:0] aIn, bIn;
    logic        invA, invB, passA, passB, andOp, orrOp, eorOp, cIn, cUse;
    logic [31:0] DATAOUT;
    logic        CFLAGOUT, VFLAGOUT, NFLAGOUT, ZFLAGOUT;

    int checks = 0;
    int errors = 0;
    bit chkEn  = 1'b0;

    arm7_alu dut (
        .CLK      (CLK),
        .nRESET   (nRESET),
        .ADATAIN  (aIn),
        .BDATAIN  (bIn),
        .INVA     (invA),
        .INVB     (invB),
        .PASSA    (passA),
        .PASSB    (passB),
        .AND_OP   (andOp),
        .ORR_OP   (orrOp),
        .EOR_OP   (eorOp),
        .CFLAGIN  (cIn),
        .CFLAGUSE (cUse),
        .DATAOUT  (DATAOUT),
        .CFLAGOUT (CFLAGOUT),
        .VFLAGOUT (VFLAGOUT),
        .NFLAGOUT (NFLAGOUT),
        .ZFLAGOUT (ZFLAGOUT)
    );

    always #5 CLK = ~CLK;

    // Reference: {N, Z, C, V, result} from plain integer arithmetic.
    function automatic logic [35:0] model();
        logic [31:0]     ap, bp, res;
        logic            c, v;
        longint unsigned uSum;
        longint          sSum, sa, sb;
        int              ci;
        ap = invA ? ~aIn : aIn;
        bp = invB ? ~bIn : bIn;
        ci = cUse ? int'(cIn) : int'(invA || invB);
        c  = cIn;
        v  = 1'b0;
        if      (passA) res = ap;
        else if (passB) res = bp;
        else if (andOp) res = ap & bp;
        else if (orrOp) res = ap | bp;
        else if (eorOp) res = ap ^ bp;
        else begin
            uSum = longint'(ap) + longint'(bp) + longint'(ci);
            res  = uSum[31:0];
            c    = (uSum > 64'hFFFF_FFFF);
            sa   = $signed(ap);
            sb   = $signed(bp);
            sSum = sa + sb + longint'(ci);
            v    = (sSum > 64'sd2147483647) || (sSum < -64'sd2147483648);
        end
        return {res[31], res == 32'h0, c, v, res};
    endfunction

    function automatic logic [35:0] dutOut();
        return {NFLAGOUT, ZFLAGOUT, CFLAGOUT, VFLAGOUT, DATAOUT};
    endfunction

    task automatic check(input string name, input logic [35:0] act, input logic [35:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got NZCV=%b data=%h required NZCV=%b data=%h",
                     name, act[35:32], act[31:0], exp[35:32], exp[31:0]);
        end
    endtask

    task automatic setOp(input logic [31:0] a, input logic [31:0] b, input logic [8:0] ctl,
                         input logic ci, input logic cu);
        aIn = a;
        bIn = b;
        {invA, invB, passA, passB, andOp, orrOp, eorOp} = ctl[6:0];
        cIn  = ci;
        cUse = cu;
    endtask

    // Apply between edges, then check one edge later against a literal.
    task automatic directed(input string name, input logic [31:0] a, input logic [31:0] b,
                            input logic [8:0] ctl, input logic ci, input logic cu,
                            input logic [35:0] exp);
        @(negedge CLK);
        setOp(a, b, ctl, ci, cu);
        @(posedge CLK);
        #1;
        check(name, dutOut(), exp);
    endtask

    function automatic logic [31:0] randOperand();
        case ($urandom_range(0, 5))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h7FFF_FFFF;
            3:       return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    always @(posedge CLK) begin
        if (chkEn) begin
            #1;
            check("model", dutOut(), model());
        end
    end

    initial begin
        logic [35:0] holdExp;
        nRESET = 1'b0;
        setOp(32'd1, 32'd1, 9'd0, 1'b0, 1'b0);
        repeat (2) @(posedge CLK);
        #1;
`ifdef ALU_OUT_REG_EN
        check("reset_hold", dutOut(), 36'h0);
        // Release between edges: outputs stay 0 until the next rising edge.
        @(negedge CLK);
        nRESET = 1'b1;
        #1;
        check("release_no_edge", dutOut(), 36'h0);
        @(posedge CLK);
        #1;
        check("first_capture", dutOut(), {4'b0000, 32'd2});
        // Asynchronous assertion mid-cycle clears at once.
        @(negedge CLK);
        nRESET = 1'b0;
        #1;
        check("async_assert", dutOut(), 36'h0);
        // Reset held over an edge discards the in-flight result.
        setOp(32'd7, 32'd8, 9'd0, 1'b0, 1'b0);
        @(posedge CLK);
        #1;
        check("inflight_discard", dutOut(), 36'h0);
        @(negedge CLK);
        nRESET = 1'b1;
        #1;
        check("release_again", dutOut(), 36'h0);
`else
        check("comb_ignores_reset", dutOut(), {4'b0000, 32'd2});
        @(negedge CLK);
        nRESET = 1'b1;
        setOp(32'd7, 32'd8, 9'd0, 1'b0, 1'b0);
        #1;
        check("comb_zero_latency", dutOut(), {4'b0000, 32'd15});
`endif
        chkEn = 1'b1;

        // ctl = {2'b0, INVA, INVB, PASSA, PASSB, AND, ORR, EOR}
        directed("add",      32'd123,        32'd234,        9'b00_0000000, 1'b0, 1'b0, {4'b0000, 32'd357});
        directed("cmp_eq",   32'd5,          32'd5,          9'b00_0100000, 1'b0, 1'b0, {4'b0110, 32'h0});
        directed("ovf",      32'h7FFF_FFFF,  32'd1,          9'b00_0000000, 1'b0, 1'b0, {4'b1001, 32'h8000_0000});
        directed("adc",      32'hFFFF_FFFF,  32'd0,          9'b00_0000000, 1'b1, 1'b1, {4'b0110, 32'h0});
        directed("and_prio", 32'hF0F0_F0F0,  32'hFF00_FF00,  9'b00_0000110, 1'b1, 1'b0, {4'b1010, 32'hF000_F000});
        directed("bic",      32'hF0F0_F0F0,  32'hFF00_FF00,  9'b00_0100100, 1'b1, 1'b0, {4'b0010, 32'h00F0_00F0});
        directed("rsb_neg",  32'd10,         32'd3,          9'b00_1000000, 1'b0, 1'b0, {4'b1000, 32'hFFFF_FFF9});
        directed("mvn_pri",  32'h1234_5678,  32'h0000_FFFF,  9'b00_0101111, 1'b0, 1'b0, {4'b1000, 32'hFFFF_0000});

        for (int i = 0; i < 600; i++) begin
            @(negedge CLK);
            holdExp = model();
            setOp(randOperand(), randOperand(),
                  {2'b00, 1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 2) == 0),
                   1'($urandom_range(0, 5) == 0), 1'($urandom_range(0, 5) == 0),
                   1'($urandom_range(0, 4) == 0), 1'($urandom_range(0, 4) == 0),
                   1'($urandom_range(0, 4) == 0)},
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            #1;
`ifdef ALU_OUT_REG_EN
            check("hold_until_edge", dutOut(), holdExp);
`else
            check("comb_now", dutOut(), model());
`endif
        end

        @(negedge CLK);
        chkEn = 1'b0;
        repeat (2) @(posedge CLK);
        #2;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
